// File: rtl/dmem_pkg.sv
// Shared types and defaults for the M-stage data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int LAT_W       = 4;
  localparam int DEF_DEPTH   = 64;
  localparam int DEF_LATENCY = 2;

endpackage

// File: rtl/dmem_wbuf.sv
// One-entry posted write buffer: forwarding hit, capture/coalesce and drain handshake.
module dmem_wbuf #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          store_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   data_i,
  input  logic          drain_ok_i,
  output logic [AW-1:0] idx_o,
  output logic [31:0]   data_o,
  output logic          hit_o,
  output logic          capture_o,
  output logic          drain_o
);

  logic          valid_q, valid_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   data_q, data_d;

  assign hit_o     = valid_q && (idx_q == idx_i);
  assign drain_o   = valid_q && drain_ok_i;
  // A same-index store may overwrite the entry even when no drain is possible.
  assign capture_o = store_i && (!valid_q || drain_o || hit_o);

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    data_d  = data_q;
    if (capture_o) begin
      valid_d = 1'b1;
      idx_d   = idx_i;
      data_d  = data_i;
    end else if (drain_o) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign idx_o  = idx_q;
  assign data_o = data_q;

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data RAM for the M stage with fixed load latency and a posted write buffer.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwritem,
  input  logic        memtoregm,
  input  logic [31:0] aluoutm,
  input  logic [31:0] writedatam,
  output logic [31:0] rdm,
  output logic        stallm,
  output logic        misalignm
);

  localparam int AW = $clog2(DEPTH);

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdm_q;
  logic               misalign_q, misalign_d;
  logic [31:0]        mem_q [DEPTH];

  logic [AW-1:0]      idx;
  logic               load_req, load_start, hit_load, rd_ram, drain_ok, ram_we;
  logic               wb_hit, wb_capture, wb_drain;
  logic [AW-1:0]      wb_idx;
  logic [31:0]        wb_data;
  logic               unused_addr;

  assign idx         = aluoutm[AW+1:2];
  assign unused_addr = ^aluoutm[31:AW+2];
  // A simultaneous store wins; the load request is dropped.
  assign load_req    = memtoregm && !memwritem;
  assign drain_ok    = (state_q == IDLE) && !load_req;
  assign ram_we      = wb_drain && !reset;

  dmem_wbuf #(.AW(AW)) u_wbuf (
    .clk        (clk),
    .reset      (reset),
    .store_i    (memwritem),
    .idx_i      (idx),
    .data_i     (writedatam),
    .drain_ok_i (drain_ok),
    .idx_o      (wb_idx),
    .data_o     (wb_data),
    .hit_o      (wb_hit),
    .capture_o  (wb_capture),
    .drain_o    (wb_drain)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stallm     = 1'b0;
    load_start = 1'b0;
    hit_load   = 1'b0;
    rd_ram     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          load_start = 1'b1;
          if (wb_hit) begin
            hit_load = 1'b1;
          end else begin
            stallm  = 1'b1;
            cnt_d   = LAT_W'(LATENCY - 1);
            state_d = (LATENCY > 1) ? WAIT : DONE;
          end
        end
      end
      WAIT: begin
        stallm = 1'b1;
        cnt_d  = cnt_q - LAT_W'(1);
        if (cnt_q == LAT_W'(1)) state_d = DONE;
      end
      DONE: begin
        rd_ram  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (memwritem && !wb_capture) stallm = 1'b1;
    // Conflicting store+load requests are flagged alongside unaligned accesses.
    misalign_d = (wb_capture && ((aluoutm[1:0] != 2'b00) || memtoregm)) ||
                 (load_start && (aluoutm[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[wb_idx] <= wb_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdm_q <= '0;
    end else if (rd_ram) begin
      rdm_q <= mem_q[idx];
    end else if (hit_load) begin
      rdm_q <= wb_data;
    end
  end

  assign rdm       = rdm_q;
  assign misalignm = misalign_q;

endmodule
